// File: rtl/re_demap_pkg.sv
// Shared constants, address widths, read-FSM states and the sample saturation
// helper for the receive-side resource-element demapper.
package re_demap_pkg;

  localparam int FFT_SIZE  = 2048;
  localparam int IN_WIDTH  = 26;
  localparam int OUT_WIDTH = 18;
  localparam int START_IDX = 423;
  localparam int NUM_RE    = 1200;

  localparam int IDX_W  = $clog2(FFT_SIZE);
  localparam int RE_AW  = $clog2(NUM_RE);
  localparam int RAM_AW = RE_AW + 1;
  localparam int RD_CW  = $clog2(NUM_RE + 1);

  typedef enum logic {IDLE, READ} rd_state_t;

  // A value fits in OUT_WIDTH iff every bit above the output sign bit
  // matches that sign bit; otherwise clamp toward the input's sign.
  function automatic logic [OUT_WIDTH-1:0] sat_trunc(input logic [IN_WIDTH-1:0] x);
    logic [IN_WIDTH-OUT_WIDTH:0] hi;
    hi = x[IN_WIDTH-1:OUT_WIDTH-1];
    if (hi == '0 || hi == '1)
      return x[OUT_WIDTH-1:0];
    else if (x[IN_WIDTH-1])
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/re_bank_ram.sv
// Two-bank RE store: simple dual-port RAM, bank select in the address MSB,
// registered read with one cycle of latency, contents never reset.
module re_bank_ram
  import re_demap_pkg::*;
(
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [RAM_AW-1:0]    wr_addr,
  input  logic [OUT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [RAM_AW-1:0]    rd_addr,
  output logic [OUT_WIDTH-1:0] rd_data
);

  logic [OUT_WIDTH-1:0] mem [0:2*NUM_RE-1];
  logic [OUT_WIDTH-1:0] rd_data_reg;

  // Banks are packed back to back so the array is exactly 2*NUM_RE deep.
  function automatic logic [RAM_AW-1:0] phys(input logic [RAM_AW-1:0] a);
    return a[RAM_AW-1] ? RAM_AW'(NUM_RE) + {1'b0, a[RE_AW-1:0]}
                       : {1'b0, a[RE_AW-1:0]};
  endfunction

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[phys(wr_addr)] <= wr_data;
    if (rd_en)
      rd_data_reg <= mem[phys(rd_addr)];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/re_demapper.sv
// Keeps the allocated subcarriers of each FFT symbol, saturates them into a
// ping-pong bank and streams completed symbols out over valid/ready.
module re_demapper
  import re_demap_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_sym_start,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 sym_err,
  output logic                 ovf
);

  localparam logic [IDX_W-1:0] START_BIN = IDX_W'(START_IDX);
  localparam logic [IDX_W-1:0] END_BIN   = IDX_W'(START_IDX + NUM_RE - 1);
  localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(FFT_SIZE - 1);
  localparam logic [RD_CW-1:0] NUM_RE_C  = RD_CW'(NUM_RE);
  localparam logic [RD_CW-1:0] LAST_RE   = RD_CW'(NUM_RE - 1);

  // ---------------- write side ----------------
  logic             in_sync_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  logic             wr_bank_reg;
  logic             drop_reg;
  logic [1:0]       bank_full_reg, bank_full_next;
  logic             sym_err_reg, ovf_reg;

  logic             accept, bin0, drop_now, wr_en, fill_done;
  logic [IDX_W-1:0] eff_idx;
  logic [RE_AW-1:0] wr_re;

  // A start flag always forces bin 0, which also recovers from a mid-symbol restart.
  assign accept    = in_valid && (in_sync_reg || in_sym_start);
  assign eff_idx   = in_sym_start ? '0 : wr_idx_reg;
  assign bin0      = (eff_idx == '0);
  assign drop_now  = bin0 ? bank_full_reg[wr_bank_reg] : drop_reg;
  assign wr_en     = accept && !drop_now && (eff_idx >= START_BIN) && (eff_idx <= END_BIN);
  assign fill_done = accept && !drop_now && (eff_idx == LAST_BIN);
  assign wr_re     = RE_AW'(eff_idx - START_BIN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_sync_reg <= 1'b0;
      wr_idx_reg  <= '0;
      wr_bank_reg <= 1'b0;
      drop_reg    <= 1'b0;
      sym_err_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      sym_err_reg <= in_valid && in_sym_start && in_sync_reg && (wr_idx_reg != '0);
      ovf_reg     <= accept && bin0 && bank_full_reg[wr_bank_reg];
      if (accept) begin
        in_sync_reg <= 1'b1;
        wr_idx_reg  <= (eff_idx == LAST_BIN) ? '0 : eff_idx + 1'b1;
        drop_reg    <= drop_now;
        if (fill_done)
          wr_bank_reg <= ~wr_bank_reg;
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_t            state_reg, state_next;
  logic [RD_CW-1:0]     rd_addr_reg, rd_addr_next;
  logic                 rd_bank_reg;
  logic                 pend_reg, pend_last_reg;
  logic [OUT_WIDTH-1:0] d0_reg, d1_reg, d0_next, d1_next;
  logic                 l0_reg, l1_reg, l0_next, l1_next;
  logic [1:0]           cnt_reg, cnt_next, occ;
  logic                 pop, rd_done, issue;
  logic [OUT_WIDTH-1:0] ram_rd_data;

  assign pop     = (cnt_reg != 2'd0) && out_ready;
  assign rd_done = pop && l0_reg;
  // Occupancy after this cycle's pop, counting the read already in flight.
  assign occ     = cnt_reg + {1'b0, pend_reg} - {1'b0, pop};
  assign issue   = (state_reg == READ) && (rd_addr_reg != NUM_RE_C) && (occ < 2'd2);

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    case (state_reg)
      IDLE: begin
        if (bank_full_reg[rd_bank_reg]) begin
          state_next   = READ;
          rd_addr_next = '0;
        end
      end
      READ: begin
        if (issue)
          rd_addr_next = rd_addr_reg + 1'b1;
        if (rd_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    d0_next  = d0_reg;
    d1_next  = d1_reg;
    l0_next  = l0_reg;
    l1_next  = l1_reg;
    cnt_next = cnt_reg;
    if (pop) begin
      d0_next  = d1_reg;
      l0_next  = l1_reg;
      cnt_next = cnt_reg - 2'd1;
    end
    if (pend_reg) begin
      if (cnt_next == 2'd0) begin
        d0_next = ram_rd_data;
        l0_next = pend_last_reg;
      end else begin
        d1_next = ram_rd_data;
        l1_next = pend_last_reg;
      end
      cnt_next = cnt_next + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      rd_addr_reg   <= '0;
      rd_bank_reg   <= 1'b0;
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
      d0_reg        <= '0;
      d1_reg        <= '0;
      l0_reg        <= 1'b0;
      l1_reg        <= 1'b0;
      cnt_reg       <= 2'd0;
    end else begin
      state_reg     <= state_next;
      rd_addr_reg   <= rd_addr_next;
      pend_reg      <= issue;
      pend_last_reg <= issue && (rd_addr_reg == LAST_RE);
      d0_reg        <= d0_next;
      d1_reg        <= d1_next;
      l0_reg        <= l0_next;
      l1_reg        <= l1_next;
      cnt_reg       <= cnt_next;
      if (rd_done)
        rd_bank_reg <= ~rd_bank_reg;
    end
  end

  // Fill of one bank and drain of the other may land on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank_full
      assign bank_full_next[gi] =
          (bank_full_reg[gi] || (fill_done && (int'(wr_bank_reg) == gi)))
          && !(rd_done && (int'(rd_bank_reg) == gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST)
      bank_full_reg <= 2'b00;
    else
      bank_full_reg <= bank_full_next;
  end

  re_bank_ram u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_reg, wr_re}),
    .wr_data (sat_trunc(in_data)),
    .rd_en   (issue),
    .rd_addr ({rd_bank_reg, RE_AW'(rd_addr_reg)}),
    .rd_data (ram_rd_data)
  );

  assign out_data  = d0_reg;
  assign out_valid = (cnt_reg != 2'd0);
  assign out_last  = l0_reg && (cnt_reg != 2'd0);
  assign sym_err   = sym_err_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_re_demapper.sv
// Randomised bench for re_demapper: a symbol-level model predicts kept,
// saturated REs and the ovf/sym_err pulses; a negedge process compares.
module tb_re_demapper;
  import re_demap_pkg::*;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [IN_WIDTH-1:0]  in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_sym_start = 1'b0;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic                 sym_err;
  logic                 ovf;

  always #5 CLK = ~CLK;

  re_demapper dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_valid(in_valid), .in_sym_start(in_sym_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sym_err(sym_err), .ovf(ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int d; bit l; } beat_t;
  beat_t               exp_q[$];
  logic [IN_WIDTH-1:0] cur_sym [0:FFT_SIZE-1];
  int  m_idx = 0, m_pend = 0;
  bit  m_sync = 0, m_drop = 0;
  bit  exp_ovf_d = 0, exp_serr_d = 0;
  bit  prev_stall = 0, prev_last = 0;
  int  prev_data = 0;
  int  obs_d [0:4095];
  bit  obs_l [0:4095];
  int  obs_n = 0, ovf_seen = 0, serr_seen = 0, sym_out = 0;

  function automatic int sat_model(input logic [IN_WIDTH-1:0] x);
    int v;
    v = int'($signed(x));
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  always @(negedge CLK) begin
    bit new_ovf, new_serr;
    beat_t b;
    int od;
    new_ovf  = 0;
    new_serr = 0;
    od = int'($signed(out_data));
    if (RST) begin
      exp_q.delete();
      m_idx = 0; m_pend = 0; m_sync = 0; m_drop = 0;
      prev_stall = 0;
    end else begin
      chk("ovf_pulse", ovf, exp_ovf_d);
      chk("sym_err_pulse", sym_err, exp_serr_d);
      if (ovf) ovf_seen++;
      if (sym_err) serr_seen++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", od, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid) chk("valid_has_expected", exp_q.size() > 0, 1);
      // input sample taken at the coming edge
      if (in_valid && (m_sync || in_sym_start)) begin
        if (in_sym_start) begin
          if (m_sync && m_idx != 0) new_serr = 1;
          m_idx = 0;
        end
        m_sync = 1;
        if (m_idx == 0) begin
          m_drop  = (m_pend == 2);
          new_ovf = m_drop;
        end
        cur_sym[m_idx] = in_data;
        if (m_idx == FFT_SIZE - 1) begin
          if (!m_drop) begin
            for (int j = 0; j < NUM_RE; j++) begin
              b.d = sat_model(cur_sym[START_IDX + j]);
              b.l = (j == NUM_RE - 1);
              exp_q.push_back(b);
            end
            m_pend++;
          end
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      // output handshake at the coming edge
      if (out_valid && out_ready && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("out_data", od, b.d);
        chk("out_last", out_last, b.l);
        if (obs_n < 4096) begin
          obs_d[obs_n] = od;
          obs_l[obs_n] = out_last;
        end
        obs_n++;
        if (b.l) begin
          m_pend--;
          sym_out++;
          $display("symbol %0d delivered, %0d beats observed in this test", sym_out, obs_n);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = od;
      prev_last  = out_last;
    end
    exp_ovf_d  = new_ovf;
    exp_serr_d = new_serr;
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;  // 0: always, 1: toggle, 2: never, 3: random
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(1));
    endcase
  end

  logic [IN_WIDTH-1:0] sym_data [0:FFT_SIZE-1];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < FFT_SIZE; k++) begin
      case (mode)
        0:       sym_data[k] = IN_WIDTH'(k - 1000);
        1:       sym_data[k] = IN_WIDTH'(int'($urandom_range(300000)) - 150000);
        default: sym_data[k] = IN_WIDTH'($urandom);
      endcase
    end
  endtask

  task automatic send_sym(input int nbins, input int gap_pct);
    for (int k = 0; k < nbins; k++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid     = 1'b0;
        in_sym_start = 1'($urandom_range(1));
        in_data      = IN_WIDTH'($urandom);
        tick();
      end
      in_valid     = 1'b1;
      in_sym_start = (k == 0);
      in_data      = sym_data[k];
      tick();
    end
    in_valid     = 1'b0;
    in_sym_start = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 20000) begin
      tick();
      g++;
    end
    chk("drain_within_budget", g < 20000, 1);
    repeat (5) tick();
  endtask

  task automatic new_test();
    obs_n = 0; ovf_seen = 0; serr_seen = 0;
  endtask

  initial begin
    int lat, guard;
    repeat (4) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sym_err", sym_err, 0);
    chk("rst_ovf", ovf, 0);
    RST = 1'b0;
    tick();

    // samples before the first start flag are ignored
    for (int k = 0; k < 50; k++) begin
      in_valid = 1'b1; in_sym_start = 1'b0; in_data = IN_WIDTH'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("unsynced_no_output", out_valid, 0);

    // single ramp symbol, latency and boundary values
    new_test(); rdy_mode = 0; fill(0);
    send_sym(FFT_SIZE, 0);
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      if (out_valid) lat = k;
      else tick();
    end
    chk("first_valid_latency", lat, 3);
    wait_drain();
    chk("ramp_beats", obs_n, 1200);
    chk("ramp_first", obs_d[0], -577);
    chk("ramp_final", obs_d[1199], 622);
    chk("ramp_last_flag", obs_l[1199], 1);
    chk("ramp_last_early", obs_l[1198], 0);

    // saturation
    new_test(); fill(0);
    sym_data[423] = IN_WIDTH'(200000);
    sym_data[424] = IN_WIDTH'(-200000);
    sym_data[425] = IN_WIDTH'(-5);
    send_sym(FFT_SIZE, 0);
    wait_drain();
    chk("sat_pos", obs_d[0], 131071);
    chk("sat_neg", obs_d[1], -131072);
    chk("sat_pass", obs_d[2], -5);

    // back-to-back with toggling ready
    new_test(); rdy_mode = 1;
    fill(1); send_sym(FFT_SIZE, 0);
    fill(1); send_sym(FFT_SIZE, 0);
    wait_drain();
    chk("b2b_beats", obs_n, 2400);
    chk("b2b_no_ovf", ovf_seen, 0);

    // overflow: third symbol has no free bank
    new_test(); rdy_mode = 2;
    for (int s = 0; s < 3; s++) begin
      fill(1); send_sym(FFT_SIZE, 0);
    end
    tick();
    chk("ovf_count", ovf_seen, 1);
    rdy_mode = 0;
    wait_drain();
    chk("ovf_beats", obs_n, 2400);

    // restart mid-symbol at bin 900
    new_test(); fill(1);
    send_sym(900, 0);
    fill(2); send_sym(FFT_SIZE, 0);
    wait_drain();
    chk("serr_count", serr_seen, 1);
    chk("serr_beats", obs_n, 1200);

    // reset in the middle of reading
    new_test(); fill(2);
    send_sym(FFT_SIZE, 0);
    guard = 0;
    while (obs_n < 600 && guard < 5000) begin
      tick();
      guard++;
    end
    chk("reached_beat_600", obs_n >= 600, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    repeat (20) tick();
    new_test(); fill(0);
    send_sym(FFT_SIZE, 0);
    wait_drain();
    chk("post_rst_beats", obs_n, 1200);
    chk("post_rst_first", obs_d[0], -577);

    // random traffic with input gaps and random ready
    new_test(); rdy_mode = 3;
    for (int s = 0; s < 5; s++) begin
      fill(2); send_sym(FFT_SIZE, 10);
    end
    wait_drain();
    chk("random_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/re_demapper.md
Name: re_demapper

Overview:
- Receive-side counterpart of the transmit resource-element mapper (ping-pong buffer).
- Takes the 2048-point FFT output stream of one OFDM symbol and keeps only the allocated subcarriers [START_IDX, START_IDX+NUM_RE-1]. Guard and zero-padded bins are discarded.
- Saturates each kept sample from IN_WIDTH to OUT_WIDTH and stores it in a ping-pong bank.
- Streams each completed symbol's REs, in order, to the downstream IDFT/equalizer over a valid/ready handshake.

Parameters:
- FFT_SIZE, 2048, samples per input symbol.
- IN_WIDTH, 26, signed FFT output sample width.
- OUT_WIDTH, 18, signed output RE width.
- START_IDX, 423, FFT bin index of the first allocated RE.
- NUM_RE, 1200, allocated REs per symbol; START_IDX+NUM_RE <= FFT_SIZE.

Ports:
- CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  reset, synchronous, active-high.
- in_data  in  IN_WIDTH  signed FFT bin sample.
- in_valid  in  1  in_data valid; no input backpressure.
- in_sym_start  in  1  qualifies the first bin (index 0) of a symbol; only meaningful with in_valid.
- out_data  out  OUT_WIDTH  signed RE.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid&&out_ready.
- out_last  out  1  marks RE NUM_RE-1 of a symbol.
- sym_err  out  1  one-cycle pulse: in_sym_start seen mid-symbol.
- ovf  out  1  one-cycle pulse: symbol dropped, no free bank.

Behaviour:
- Reset (RST=1 at an edge):
  - out_data=0, out_valid=0, out_last=0, sym_err=0, ovf=0.
  - wr_idx=0, wr_bank=0, rd_bank=0, bank_full=2'b00, in_sync=0, FSM=IDLE, output stage empty.
  - RAM contents are not cleared; every allocated location is rewritten each symbol.
  - Reset mid-operation aborts both sides immediately.
- Input sync:
  - Samples are ignored until the first in_valid&&in_sym_start; that sample sets in_sync=1 and is bin 0.
  - wr_idx increments on each accepted sample and wraps 2047->0.
  - in_sym_start with wr_idx!=0 while in_sync: sym_err pulses, the partial symbol is discarded (bank not marked full), and the sample is treated as bin 0.
  - in_sym_start is not required at wr_idx==0 after wrap; wrap itself starts the next symbol.
- Write side:
  - At bin 0, drop = bank_full[wr_bank].
  - If drop: ovf pulses that cycle and the entire symbol is not written.
  - Otherwise bins START_IDX..START_IDX+NUM_RE-1 are written to RAM[wr_bank][bin-START_IDX].
  - Saturation: values > 2^(OUT_WIDTH-1)-1 clamp to 131071; values < -2^(OUT_WIDTH-1) clamp to -131072; otherwise keep the low OUT_WIDTH bits.
  - On acceptance of bin FFT_SIZE-1 of a non-dropped symbol: bank_full[wr_bank]<=1 and wr_bank toggles.
- Read FSM:
  - IDLE: if bank_full[rd_bank], go to READ with rd_addr=0.
  - READ: issue RAM reads (1-cycle latency) into a 2-entry output skid buffer.
    - Reads are issued while the buffer has space, so full throughput is maintained under out_ready=1.
    - out_data/out_valid come from the buffer head.
  - When RE NUM_RE-1 is accepted (out_last&&out_valid&&out_ready): bank_full[rd_bank]<=0, rd_bank toggles, go to IDLE.
- Latency and ordering:
  - With out_ready=1, out_valid first asserts exactly 3 cycles after the edge accepting bin FFT_SIZE-1.
  - A symbol then delivers NUM_RE consecutive beats.
  - A minimum 1-cycle bubble separates symbols.
- Backpressure: out_data and out_last hold stable while out_valid&&!out_ready. No RE is lost or duplicated.
- Simultaneous set/clear: bank fill-complete on one bank and read-complete on the other in the same cycle both take effect.
- Write and read never target the same bank concurrently.

Decomposition:
- Package re_demap_pkg holds:
  - constants FFT_SIZE, START_IDX, NUM_RE, IN_WIDTH, OUT_WIDTH;
  - derived address widths (clog2);
  - FSM state enum {IDLE, READ};
  - function sat_trunc(in) for the IN_WIDTH->OUT_WIDTH saturation.
- One sub-module re_bank_ram:
  - simple dual-port synchronous RAM, depth 2*NUM_RE, width OUT_WIDTH;
  - bank bit is the address MSB;
  - 1 write port, 1 read port, 1-cycle read latency, no reset.

Test Plan:
- Single symbol: bin k carries value k-1000 (bins 0..2047, sym_start at 0), out_ready=1 -> 1200 beats, values -577..622, out_last only on beat 1199, first out_valid 3 cycles after bin 2047.
- Saturation: bins 423/424/425 = +200000, -200000, -5 -> out beats 0/1/2 = 131071, -131072, -5.
- Back-to-back symbols with out_ready toggling 1,0 every cycle -> both symbols delivered complete and in order, outputs stable while stalled, ovf never pulses.
- Overflow: out_ready=0 while 3 symbols are fed -> ovf pulses at bin 0 of symbol 3; releasing out_ready yields exactly symbols 1 and 2.
- Mid-symbol in_sym_start at wr_idx=900 -> sym_err pulses once, partial symbol never output, the following full symbol is output correctly.
- RST asserted during READ at beat 600 -> next cycle out_valid=0, bank_full=0; a new symbol afterwards outputs normally from beat 0.
